// File: rtl/fetch_unit_pkg.sv
// Shared instruction-bundle format and fetch-stage constants.
// Bundle layout: instr, imm, imm2 at consecutive word addresses.
package fetch_unit_pkg;

  localparam int WORD            = 32;
  localparam int ADDR_W          = 32;
  localparam int DEPTH           = 2;
  localparam int CNT_W           = 2;
  localparam int PTR_W           = 1;
  localparam int OPSIZE          = 8;
  localparam int WORDS_PER_INSTR = 3;
  localparam int OP_LSB          = WORD - OPSIZE;
  localparam int OP_MSB          = WORD - 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD0,
    ST_RD1,
    ST_RD2
  } fetch_state_e;

  typedef struct packed {
    logic [WORD-1:0]   instr;
    logic [WORD-1:0]   imm;
    logic [WORD-1:0]   imm2;
    logic [ADDR_W-1:0] pc;
  } bundle_t;

  // Instruction index/offset to word address; wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] instr_to_addr(input logic [WORD-1:0] n);
    return ADDR_W'(n) * ADDR_W'(WORDS_PER_INSTR);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry bundle FIFO; flush wins over push and pop in the same cycle.
module fetch_fifo
  import fetch_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  bundle_t          wdata,
  input  logic             pop,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output bundle_t          head
);

  bundle_t          ent_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [DEPTH-1:0] we;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = ent_q[rd_ptr_q];
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign count_d = flush ? '0 : count_q + CNT_W'(do_push) - CNT_W'(do_pop);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
    assign we[gi] = do_push & (wr_ptr_q == PTR_W'(gi));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (we[i]) ent_q[i] <= wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads 3-word bundles from a 1-cycle memory,
// queues them, and applies absolute/relative jump redirects.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WORD-1:0]   mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD-1:0]   out_instr,
  output logic [WORD-1:0]   out_imm,
  output logic [WORD-1:0]   out_imm2,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              redir_abs,
  input  logic              redir_rel,
  input  logic [WORD-1:0]   redir_target,
  input  logic [WORD-1:0]   redir_offset,
  output logic              idle
);

  fetch_state_e      state_q;
  // fpc_q is the read base and moves on at RD2; pc_q tags the bundle and
  // moves on at push, one cycle later, so back-to-back bundles overlap.
  logic [ADDR_W-1:0] fpc_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] last_pc_q;
  logic              cap_vld_q;
  logic [1:0]        cap_slot_q;
  logic [WORD-1:0]   word0_q;
  logic [WORD-1:0]   word1_q;

  logic              redir;
  logic [ADDR_W-1:0] redir_pc;
  logic              in_flight;
  logic              start;
  logic [1:0]        rd_slot;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  bundle_t           fifo_wdata;
  bundle_t           fifo_head;

  assign redir     = redir_abs | redir_rel;
  assign redir_pc  = redir_abs ? instr_to_addr(redir_target)
                               : last_pc_q + instr_to_addr(redir_offset);
  assign in_flight = (state_q != ST_IDLE) | cap_vld_q;
  assign start     = fetch_en & ~fifo_full &
                     ((3'(fifo_count) + 3'(in_flight)) < 3'(DEPTH));
  assign mem_re    = (state_q != ST_IDLE);
  assign fifo_push = cap_vld_q & (cap_slot_q == 2'd2);
  assign fifo_pop  = out_valid & out_ready;
  assign fifo_wdata = '{instr: word0_q, imm: word1_q, imm2: mem_rdata, pc: pc_q};

  always_comb begin
    mem_addr = '0;
    rd_slot  = 2'd0;
    unique case (state_q)
      ST_RD0:  begin mem_addr = fpc_q;                rd_slot = 2'd0; end
      ST_RD1:  begin mem_addr = fpc_q + ADDR_W'(1);   rd_slot = 2'd1; end
      ST_RD2:  begin mem_addr = fpc_q + ADDR_W'(2);   rd_slot = 2'd2; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      fpc_q      <= '0;
      pc_q       <= '0;
      last_pc_q  <= '0;
      cap_vld_q  <= 1'b0;
      cap_slot_q <= 2'd0;
      word0_q    <= '0;
      word1_q    <= '0;
    end else begin
      cap_vld_q  <= mem_re & ~redir;
      cap_slot_q <= rd_slot;
      if (cap_vld_q && cap_slot_q == 2'd0) word0_q <= mem_rdata;
      if (cap_vld_q && cap_slot_q == 2'd1) word1_q <= mem_rdata;
      if (fifo_pop) last_pc_q <= out_pc;
      if (redir) begin
        state_q <= ST_IDLE;
        fpc_q   <= redir_pc;
        pc_q    <= redir_pc;
      end else begin
        if (fifo_push) pc_q <= pc_q + ADDR_W'(WORDS_PER_INSTR);
        unique case (state_q)
          ST_IDLE: if (start) state_q <= ST_RD0;
          ST_RD0:  state_q <= ST_RD1;
          ST_RD1:  state_q <= ST_RD2;
          ST_RD2: begin
            fpc_q   <= fpc_q + ADDR_W'(WORDS_PER_INSTR);
            state_q <= start ? ST_RD0 : ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  fetch_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .flush (redir),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (fifo_head)
  );

  assign out_valid = ~fifo_empty;
  assign out_instr = fifo_head.instr;
  assign out_imm   = fifo_head.imm;
  assign out_imm2  = fifo_head.imm2;
  assign out_pc    = fifo_head.pc;
  assign idle      = fifo_empty & (state_q == ST_IDLE) & ~cap_vld_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed timing scenarios plus random traffic
// checked against a bundle-sequence model (pc order, memory contents, jumps).
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic        mem_re;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr, out_imm, out_imm2, out_pc;
  logic        redir_abs = 1'b0;
  logic        redir_rel = 1'b0;
  logic [31:0] redir_target = 32'h0;
  logic [31:0] redir_offset = 32'h0;
  logic        idle;

  int vectors = 0;
  int miscompares = 0;
  int pops = 0;

  logic [31:0] exp_pc = 32'h0;
  logic [31:0] last_pc = 32'h0;
  logic        chk_flush = 1'b0;
  logic        chk_hold = 1'b0;
  logic [31:0] held_instr, held_imm2, held_pc;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_imm(out_imm), .out_imm2(out_imm2), .out_pc(out_pc),
    .redir_abs(redir_abs), .redir_rel(redir_rel),
    .redir_target(redir_target), .redir_offset(redir_offset),
    .idle(idle)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a + 32'h100;
  endfunction

  // Single-port memory with one cycle of read latency.
  always @(posedge clk) mem_rdata <= mem_re ? mem_word(mem_addr) : 32'hDEADBEEF;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Evaluate the bundle-sequence model on the values present just before the edge.
  task automatic model_pre();
    logic pop;
    logic redir;
    logic [31:0] popped;
    pop   = out_valid & out_ready;
    redir = redir_abs | redir_rel;
    popped = exp_pc;
    if (chk_flush) begin
      check("flush_valid", out_valid, 1'b0);
      chk_flush = 1'b0;
    end
    if (chk_hold) begin
      check("hold_valid", out_valid, 1'b1);
      check("hold_instr", out_instr, held_instr);
      check("hold_imm2", out_imm2, held_imm2);
      check("hold_pc", out_pc, held_pc);
      chk_hold = 1'b0;
    end
    check("push_into_full", dut.fifo_push & dut.fifo_full, 1'b0);
    if (pop) begin
      check("pop_pc", out_pc, exp_pc);
      check("pop_instr", out_instr, mem_word(exp_pc));
      check("pop_imm", out_imm, mem_word(exp_pc + 32'd1));
      check("pop_imm2", out_imm2, mem_word(exp_pc + 32'd2));
      $display("pop pc=%h instr=%h imm=%h imm2=%h", out_pc, out_instr, out_imm, out_imm2);
      pops++;
      exp_pc = exp_pc + 32'd3;
    end
    if (out_valid && !out_ready && !redir) begin
      chk_hold   = 1'b1;
      held_instr = out_instr;
      held_imm2  = out_imm2;
      held_pc    = out_pc;
    end
    if (redir) begin
      exp_pc    = redir_abs ? redir_target * 32'd3 : last_pc + redir_offset * 32'd3;
      chk_flush = 1'b1;
    end
    if (pop) last_pc = popped;
  endtask

  task automatic step();
    model_pre();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; fetch_en = 1'b0; out_ready = 1'b0;
    redir_abs = 1'b0; redir_rel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_pc = 32'h0; last_pc = 32'h0; chk_flush = 1'b0; chk_hold = 1'b0;
  endtask

  task automatic wait_read(input string tag);
    int n = 0;
    while (!mem_re && n < 12) begin step(); n++; end
    check(tag, n < 12, 1'b1);
  endtask

  task automatic wait_rd1(input string tag);
    int n = 0;
    while (!(mem_re && (mem_addr % 3) == 1) && n < 20) begin step(); n++; end
    check(tag, n < 20, 1'b1);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 12) begin step(); n++; end
    check(tag, n < 12, 1'b1);
  endtask

  initial begin
    // Reset state and first-bundle latency / throughput
    do_reset();
    check("rst_mem_re", mem_re, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_instr", out_instr, 32'h0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_idle", idle, 1'b1);
    fetch_en = 1'b1; out_ready = 1'b1;
    step(); check("c0_addr", mem_re ? mem_addr : 32'hFFFF_FFF0, 32'h0);
    step(); check("c1_addr", mem_addr, 32'h1);
    step(); check("c2_addr", mem_addr, 32'h2);
    step(); check("c3_b2b_addr", mem_addr, 32'h3);
            check("c3_valid", out_valid, 1'b0);
    step(); check("c4_valid", out_valid, 1'b1);
            check("c4_instr", out_instr, 32'h100);
            check("c4_imm", out_imm, 32'h101);
            check("c4_imm2", out_imm2, 32'h102);
            check("c4_pc", out_pc, 32'h0);
    repeat (3) step();
    check("c7_valid", out_valid, 1'b1);
    check("c7_pc", out_pc, 32'h3);

    // Back-pressure: two bundles queued, then fetch stalls
    do_reset();
    fetch_en = 1'b1;
    repeat (12) step();
    check("full_mem_re", mem_re, 1'b0);
    check("full_idle", idle, 1'b0);
    check("full_instr", out_instr, 32'h100);
    check("full_imm", out_imm, 32'h101);
    check("full_pc", out_pc, 32'h0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    wait_read("refetch_timeout");
    check("refetch_addr", mem_addr, 32'h6);

    // Relative jump while RD1 in flight
    do_reset();
    fetch_en = 1'b1; out_ready = 1'b1;
    begin
      int n = 0;
      while (!(out_valid && out_pc == 32'h9) && n < 40) begin step(); n++; end
      check("pc9_timeout", n < 40, 1'b1);
    end
    step();
    out_ready = 1'b0;
    wait_rd1("rel_rd1_timeout");
    redir_rel = 1'b1; redir_offset = 32'hFFFF_FFFE;
    step();
    redir_rel = 1'b0; out_ready = 1'b1;
    check("rel_flush_valid", out_valid, 1'b0);
    wait_read("rel_read_timeout");
    check("rel_addr", mem_addr, 32'h3);
    wait_valid("rel_valid_timeout");
    check("rel_out_pc", out_pc, 32'h3);

    // Simultaneous abs and rel: abs wins
    redir_abs = 1'b1; redir_target = 32'd5;
    redir_rel = 1'b1; redir_offset = 32'd1;
    step();
    redir_abs = 1'b0; redir_rel = 1'b0;
    wait_read("abs_read_timeout");
    check("abs_addr", mem_addr, 32'd15);

    // fetch_en dropped during RD1: bundle completes, then idle
    step();
    check("fe_rd1_addr", mem_addr, 32'd16);
    fetch_en = 1'b0; out_ready = 1'b0;
    step();
    check("fe_rd2_re", mem_re, 1'b1);
    check("fe_rd2_addr", mem_addr, 32'd17);
    repeat (5) step();
    check("fe_stop_re", mem_re, 1'b0);
    check("fe_valid", out_valid, 1'b1);
    check("fe_pc", out_pc, 32'd15);
    check("fe_idle", idle, 1'b0);

    // Async reset mid-bundle
    fetch_en = 1'b1; out_ready = 1'b1;
    wait_rd1("arst_rd1_timeout");
    rst_n = 1'b0;
    #1;
    check("arst_mem_re", mem_re, 1'b0);
    check("arst_mem_addr", mem_addr, 32'h0);
    check("arst_valid", out_valid, 1'b0);
    check("arst_instr", out_instr, 32'h0);
    check("arst_pc", out_pc, 32'h0);
    check("arst_idle", idle, 1'b1);
    do_reset();

    // Address wrap
    fetch_en = 1'b1; out_ready = 1'b1;
    redir_abs = 1'b1; redir_target = 32'h5555_5555;
    step();
    redir_abs = 1'b0;
    wait_read("wrap_read_timeout");
    check("wrap_addr0", mem_addr, 32'hFFFF_FFFF);
    step(); check("wrap_addr1", mem_addr, 32'h0);
    step(); check("wrap_addr2", mem_addr, 32'h1);
    wait_valid("wrap_valid_timeout");
    check("wrap_pc", out_pc, 32'hFFFF_FFFF);
    check("wrap_instr", out_instr, 32'hFF);
    step();
    wait_valid("wrap_next_timeout");
    check("wrap_next_pc", out_pc, 32'h2);

    // Random traffic against the sequence model
    for (int c = 0; c < 3000; c++) begin
      fetch_en     = ($urandom_range(0, 9) != 0);
      out_ready    = ($urandom_range(0, 3) != 0);
      redir_abs    = ($urandom_range(0, 39) == 0);
      redir_rel    = ($urandom_range(0, 39) == 0);
      redir_target = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 50));
      redir_offset = 32'($urandom_range(0, 20)) - 32'd10;
      step();
    end
    redir_abs = 1'b0; redir_rel = 1'b0; fetch_en = 1'b0; out_ready = 1'b1;
    repeat (10) step();
    check("random_liveness", pops > 300, 1'b1);
    check("drain_idle", idle, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage sitting directly upstream of the core's decode/execute/write-back controller. Each instruction is a 3-word bundle (instr, imm, imm2) at consecutive word addresses. The unit reads these words from a single-port, 1-cycle-latency instruction memory and queues whole bundles in a 2-entry FIFO. It presents bundles to the core over a valid/ready handshake and applies absolute and relative jump redirects, replacing the core's inline PC handling.

Parameters:
WORD, 32, data word width
ADDR_W, 32, word-address width; all PC arithmetic is modulo 2^ADDR_W
DEPTH, 2, bundle FIFO depth; fixed at 2 for this revision

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
fetch_en  in  1  when low, no new bundle fetch starts
mem_re  out  1  memory read strobe (combinational from state)
mem_addr  out  ADDR_W  memory word address (combinational from state)
mem_rdata  in  WORD  read data, valid the cycle after mem_re
out_valid  out  1  FIFO head bundle valid
out_ready  in  1  core accepts head bundle
out_instr  out  WORD  head bundle word 0
out_imm  out  WORD  head bundle word 1
out_imm2  out  WORD  head bundle word 2
out_pc  out  ADDR_W  word address of head bundle word 0
redir_abs  in  1  absolute jump; target = redir_target*3
redir_rel  in  1  relative jump; target = last_pc + redir_offset*3
redir_target  in  WORD  absolute instruction index
redir_offset  in  WORD  signed instruction offset
idle  out  1  FIFO empty and no bundle in flight

Behaviour:
- Reset (async, rst_n low): pc=0, last_pc=0, FIFO empty, FSM=IDLE, pending read discarded. mem_re=0, mem_addr=0, out_valid=0, out_instr/out_imm/out_imm2/out_pc=0, idle=1. Reset asserted mid-bundle drops all partial state.
- FSM states: IDLE, RD0, RD1, RD2.
  - IDLE -> RD0 when fetch_en=1 and FIFO count < DEPTH.
  - RD0: mem_re=1, mem_addr=pc; next state RD1.
  - RD1: mem_re=1, mem_addr=pc+1; next state RD2.
  - RD2: mem_re=1, mem_addr=pc+2. Next state is RD0 if the start condition holds, else IDLE.
- Data capture: mem_rdata is captured at the end of the cycle after each read, into word slot 0/1/2. Capture of slot 2 pushes {words, pc} into the FIFO and advances pc by 3 on the same edge.
- Start condition: fetch_en=1 and (registered FIFO count + bundle in flight) < DEPTH. A pop in the same cycle does not free a slot until the next cycle.
- Timing:
  - Latency: first RD0 cycle N gives out_valid=1 in cycle N+4.
  - Throughput: one bundle per 3 cycles while fetch_en=1 and not full.
- Handshake:
  - Pop on out_valid & out_ready.
  - Head outputs are stable while out_valid=1 and out_ready=0.
  - On pop, last_pc <= out_pc.
  - out_ready with out_valid=0 is ignored.
- Redirects:
  - redir_abs and redir_rel are pulses. If both are high, redir_abs wins.
  - Redirect cycle effects: FIFO flushed, FSM -> IDLE, read data returning next cycle is discarded, pc <= target.
  - A pop in the redirect cycle still updates last_pc, but the rel target always uses the pre-edge last_pc.
  - out_valid=0 from the next cycle. RD0 at the new pc no earlier than the cycle after the redirect.
- fetch_en low: blocks new starts only. A bundle in flight completes and is pushed. The FIFO still drains.
- Overflow: pc+3, target*3 and offset*3 wrap modulo 2^ADDR_W; offset is sign-extended before multiply.
- FIFO full: no start; never overwrite. Pushing into a full FIFO is impossible by the start condition; the bench asserts this.
- idle = FIFO empty and FSM=IDLE and no pending capture.

Decomposition:
- Shared format header: WORD, OPSIZE, instruction field positions, WORDS_PER_INSTR=3 constant. fetch_unit uses WORDS_PER_INSTR for all *3 arithmetic.
- One sub-module: fetch_fifo.
  - 2-entry FIFO of {instr, imm, imm2, pc}.
  - Ports: push, pop, flush, full, empty, count, head.
  - flush has priority over push in the same cycle.

Test Plan:
- Reset then fetch_en=1, memory word i = 0x100+i, out_ready=1 -> reads at addr 0,1,2 in cycles 0-2. out_valid in cycle 4 with instr=0x100, imm=0x101, imm2=0x102, out_pc=0. Next bundle out_pc=3, 3 cycles later.
- out_ready=0 held -> two bundles (pc 0, 3) fetched, then mem_re stays 0 and idle=0. Head stays 0x100/0x101/0x102. Releasing out_ready pops pc 0, refetch starts at pc 6 the next cycle.
- Pop bundle pc=9, then redir_rel with offset=-2 while RD1 is in flight -> in-flight data dropped, FIFO flushed, next RD0 addr=3, next out_pc=3.
- redir_abs with target=5 and redir_rel with offset=1 in the same cycle -> next fetch at addr 15; rel ignored.
- fetch_en dropped during RD1 -> bundle completes and is pushed, then IDLE, mem_re=0. rst_n pulsed low mid-RD1 -> all outputs 0 immediately, idle=1.
- pc=0xFFFFFFFE with redir_abs target 0x55555555 -> fetch addr 0xFFFFFFFF. Sequence 0xFFFFFFFF, 0x0, 0x1; next pc=0x2.
